// File: rtl/brownout_rate_monitor.sv
// Voltage brownout detector: flags samples that fall more than DROP_THR below the sample DEPTH accepted samples earlier; BROWNOUT_STICKY_EN latches trips until clear/en low.
// Latency: drop_rate, Brownout and event_cnt update on the same edge that accepts the sample.
// Backpressure: none; every sample presented with en=1 and sample_valid=1 is consumed.
module brownout_rate_monitor #(
    parameter int                DATA_W   = 8,
    parameter int                DEPTH    = 1,
    parameter logic [DATA_W-1:0] DROP_THR = DATA_W'(7),
    parameter int                CONFIRM  = 1,
    parameter int                HOLD_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] in_bus,
    input  logic              clear,
    output logic              Brownout,
    output logic [DATA_W-1:0] drop_rate,
    output logic [7:0]        event_cnt
);
    localparam int          FILL_W   = $clog2(DEPTH + 1);
    localparam logic [7:0]  HOLD_VAL = 8'(HOLD_CYC);
    localparam logic [3:0]  CONF_TOP = 4'(CONFIRM - 1);

    typedef enum logic [1:0] {ST_PRIME, ST_MONITOR, ST_TRIPPED} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_hist [DEPTH];
    logic [FILL_W-1:0] r_fill;
    logic [3:0]        r_confirm;
    logic [7:0]        r_hold;
    logic              r_brownout;
    logic [DATA_W-1:0] r_drop_rate;
    logic [7:0]        r_event_cnt;

    logic [DATA_W-1:0] w_oldest;
    logic [DATA_W-1:0] w_drop;
    logic              w_exceed;
    logic [7:0]        w_event_base;
    logic [7:0]        w_event_inc;

    // Drop saturates at zero for rising or flat voltage.
    assign w_oldest     = r_hist[DEPTH-1];
    assign w_drop       = (w_oldest > in_bus) ? (w_oldest - in_bus) : '0;
    assign w_exceed     = (w_drop > DROP_THR);
    assign w_event_base = clear ? 8'd0 : r_event_cnt;
    assign w_event_inc  = (w_event_base == 8'hFF) ? 8'hFF : (w_event_base + 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_PRIME;
            for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
            r_fill      <= '0;
            r_confirm   <= '0;
            r_hold      <= '0;
            r_brownout  <= 1'b0;
            r_drop_rate <= '0;
            r_event_cnt <= '0;
        end else if (!en) begin
            r_state     <= ST_PRIME;
            for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
            r_fill      <= '0;
            r_confirm   <= '0;
            r_hold      <= '0;
            r_brownout  <= 1'b0;
            r_drop_rate <= '0;
            r_event_cnt <= w_event_base;
        end else begin
            r_event_cnt <= w_event_base;
            if (sample_valid) begin
                for (int i = DEPTH - 1; i > 0; i--) r_hist[i] <= r_hist[i-1];
                r_hist[0] <= in_bus;
            end
            case (r_state)
                ST_PRIME: begin
                    if (sample_valid) begin
                        r_fill <= r_fill + 1'b1;
                        if (r_fill == FILL_W'(DEPTH - 1)) r_state <= ST_MONITOR;
                    end
                end
                ST_MONITOR: begin
                    if (sample_valid) begin
                        r_drop_rate <= w_drop;
                        if (w_exceed) begin
                            if (r_confirm == CONF_TOP) begin
                                r_state     <= ST_TRIPPED;
                                r_brownout  <= 1'b1;
                                r_hold      <= HOLD_VAL;
                                r_confirm   <= '0;
                                r_event_cnt <= w_event_inc;
                            end else begin
                                r_confirm <= r_confirm + 4'd1;
                            end
                        end else begin
                            r_confirm <= '0;
                        end
                    end
                end
                ST_TRIPPED: begin
                    if (sample_valid) r_drop_rate <= w_drop;
`ifdef BROWNOUT_STICKY_EN
                    if (clear) begin
                        r_state    <= ST_MONITOR;
                        r_brownout <= 1'b0;
                        r_hold     <= '0;
                    end else if (sample_valid && w_exceed) begin
                        r_hold <= HOLD_VAL;
                    end
`else
                    // A fresh exceeding sample outranks the countdown on the same edge.
                    if (sample_valid && w_exceed) begin
                        r_hold <= HOLD_VAL;
                    end else if (r_hold <= 8'd1) begin
                        r_state    <= ST_MONITOR;
                        r_brownout <= 1'b0;
                        r_hold     <= '0;
                    end else begin
                        r_hold <= r_hold - 8'd1;
                    end
`endif
                end
                default: begin
                    r_state <= ST_PRIME;
                end
            endcase
        end
    end

    assign Brownout  = r_brownout;
    assign drop_rate = r_drop_rate;
    assign event_cnt = r_event_cnt;

endmodule

// File: tb/tb_brownout_rate_monitor.sv
// Bench for brownout_rate_monitor: directed literal checks, per-cycle model compare under random stimulus.
module tb_brownout_rate_monitor;
    localparam int DEPTH = 1;
    localparam int THR   = 7;
    localparam int CONF  = 1;
    localparam int HOLD  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, sample_valid = 1'b0, clear = 1'b0;
    logic [7:0] in_bus = 8'd0;
    logic       Brownout;
    logic [7:0] drop_rate, event_cnt;

    logic       en3 = 1'b0, sv3 = 1'b0, clr3 = 1'b0;
    logic [7:0] in3 = 8'd0;
    logic       bo3;
    logic [7:0] dr3, ec3;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    brownout_rate_monitor #(.DATA_W(8), .DEPTH(DEPTH), .DROP_THR(8'(THR)), .CONFIRM(CONF), .HOLD_CYC(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sample_valid(sample_valid), .in_bus(in_bus),
        .clear(clear), .Brownout(Brownout), .drop_rate(drop_rate), .event_cnt(event_cnt));

    brownout_rate_monitor #(.DATA_W(8), .DEPTH(3), .DROP_THR(8'd7), .CONFIRM(2), .HOLD_CYC(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en3), .sample_valid(sv3), .in_bus(in3),
        .clear(clr3), .Brownout(bo3), .drop_rate(dr3), .event_cnt(ec3));

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: history queue of accepted samples, trip lasts until HOLD cycles pass
    // without an exceeding sample (or until clear in sticky builds).
    int unsigned m_hist[$];
    int          m_run, m_ev, m_drop, m_d;
    bit          m_trip, m_was;
    longint      m_cyc, m_tlast;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hist.delete();
            m_run = 0; m_ev = 0; m_drop = 0; m_trip = 0; m_cyc = 0; m_tlast = 0;
        end else begin
            m_cyc++;
            m_was = m_trip;
            if (!en) begin
                m_hist.delete();
                m_run = 0; m_trip = 0; m_drop = 0;
                if (clear) m_ev = 0;
            end else begin
                if (clear) m_ev = 0;
                if (sample_valid) begin
                    if (m_hist.size() == DEPTH) begin
                        m_d = (m_hist[0] > in_bus) ? int'(m_hist[0]) - int'(in_bus) : 0;
                        m_drop = m_d;
                        if (m_was) begin
                            if (m_d > THR) m_tlast = m_cyc;
                        end else begin
                            m_run = (m_d > THR) ? m_run + 1 : 0;
                            if (m_run == CONF) begin
                                m_trip = 1; m_tlast = m_cyc; m_run = 0;
                                if (m_ev < 255) m_ev++;
                            end
                        end
                        void'(m_hist.pop_front());
                    end
                    m_hist.push_back(in_bus);
                end
`ifdef BROWNOUT_STICKY_EN
                if (m_was && clear) m_trip = 0;
`else
                if (m_trip && (m_cyc - m_tlast >= HOLD)) m_trip = 0;
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            chk("model_brownout", Brownout, m_trip);
            chk("model_drop_rate", drop_rate, m_drop);
            chk("model_event_cnt", event_cnt, m_ev);
        end
    end

    task automatic put(input logic v, input logic [7:0] s);
        sample_valid = v; in_bus = s;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) put(1'b0, 8'd0);
    endtask

    task automatic flush();
        en = 1'b0; put(1'b0, 8'd0); en = 1'b1;
    endtask

    task automatic put3(input logic [7:0] s);
        sv3 = 1'b1; in3 = s;
        @(negedge clk);
        sv3 = 1'b0;
    endtask

    initial begin
        int v;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_on = 1'b1;
        chk("reset_brownout", Brownout, 0);
        chk("reset_drop_rate", drop_rate, 0);
        chk("reset_event_cnt", event_cnt, 0);

        // 200 then 192: drop 8 trips immediately
        en = 1'b1;
        put(1'b1, 8'd200);
        chk("prime_drop_rate", drop_rate, 0);
        chk("prime_brownout", Brownout, 0);
        put(1'b1, 8'd192);
        chk("trip_drop_rate", drop_rate, 8);
        chk("trip_brownout", Brownout, 1);
        chk("trip_event_cnt", event_cnt, 1);
`ifndef BROWNOUT_STICKY_EN
        idle(3);
        chk("hold_3clk_brownout", Brownout, 1);
        idle(1);
        chk("hold_4clk_brownout", Brownout, 0);
`endif
        // drop equal to threshold, then rising voltage
        flush();
        put(1'b1, 8'd200);
        put(1'b1, 8'd193);
        chk("thr_equal_drop_rate", drop_rate, 7);
        chk("thr_equal_brownout", Brownout, 0);
        flush();
        put(1'b1, 8'd100);
        put(1'b1, 8'd150);
        chk("rising_drop_rate", drop_rate, 0);
        chk("rising_event_cnt", event_cnt, 1);

        // clear coincident with trip, then reload two clocks later
        flush();
        put(1'b1, 8'd200);
        clear = 1'b1;
        put(1'b1, 8'd192);
        clear = 1'b0;
        chk("clear_trip_event_cnt", event_cnt, 1);
        idle(1);
        put(1'b1, 8'd183);
        chk("reload_drop_rate", drop_rate, 9);
        chk("reload_brownout", Brownout, 1);
`ifndef BROWNOUT_STICKY_EN
        idle(3);
        chk("reload_3clk_brownout", Brownout, 1);
        idle(1);
        chk("reload_4clk_brownout", Brownout, 0);
        chk("reload_event_cnt", event_cnt, 1);
`endif
        // en low mid-trip
        flush();
        put(1'b1, 8'd200);
        put(1'b1, 8'd192);
        idle(1);
        chk("pre_en_low_brownout", Brownout, 1);
        en = 1'b0;
        put(1'b0, 8'd0);
        chk("en_low_brownout", Brownout, 0);
        chk("en_low_drop_rate", drop_rate, 0);
        chk("en_low_event_cnt", event_cnt, 2);
        en = 1'b1;

        // asynchronous reset mid-trip
        put(1'b1, 8'd200);
        put(1'b1, 8'd192);
        chk("pre_rst_brownout", Brownout, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_brownout", Brownout, 0);
        chk("async_rst_event_cnt", event_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        put(1'b1, 8'd200);
        chk("reprime_brownout", Brownout, 0);
        chk("reprime_drop_rate", drop_rate, 0);
        put(1'b1, 8'd192);
        chk("reprime_trip_brownout", Brownout, 1);

        // DEPTH=3, CONFIRM=2 instance
        en3 = 1'b1;
        put3(8'd200); put3(8'd200); put3(8'd200);
        chk("d3_prime_drop_rate", dr3, 0);
        put3(8'd190);
        chk("d3_first_drop", dr3, 10);
        chk("d3_first_brownout", bo3, 0);
        put3(8'd180);
        chk("d3_second_drop", dr3, 20);
        chk("d3_trip_brownout", bo3, 1);
        chk("d3_trip_event_cnt", ec3, 1);
        en3 = 1'b0;

`ifdef BROWNOUT_STICKY_EN
        flush();
        put(1'b1, 8'd200);
        put(1'b1, 8'd192);
        idle(300);
        chk("sticky_hold_brownout", Brownout, 1);
        clear = 1'b1;
        put(1'b0, 8'd0);
        clear = 1'b0;
        chk("sticky_clear_brownout", Brownout, 0);
        chk("sticky_clear_event_cnt", event_cnt, 0);
`endif

        // random walk around the threshold
        v = 128;
        for (int n = 0; n < 4000; n++) begin
            en = ($urandom_range(0, 99) > 2);
            clear = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 39) == 0) v = $urandom_range(0, 255);
            else v = v + $urandom_range(0, 20) - 12;
            if (v < 0) v = 0;
            if (v > 255) v = 255;
            sample_valid = ($urandom_range(0, 9) < 6);
            in_bus = 8'(v);
            @(negedge clk);
        end
        en = 1'b1; clear = 1'b0; sample_valid = 1'b0;

        // event counter saturation
        for (int n = 0; n < 300; n++) begin
            flush();
            put(1'b1, 8'd200);
            put(1'b1, 8'd190);
        end
        chk("saturated_event_cnt", event_cnt, 255);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
